// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned CLAMP_W = 32;

  typedef enum logic {IDLE, RUN} state_t;

  // Divisors of 0 or 1 cannot form a period; force them up to the minimum.
  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] d);
    return (d < CLAMP_W'(DIV_MIN)) ? CLAMP_W'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/duty_fix_neg.sv
// Half-cycle duty correction for odd divisors: negedge copy of the posedge phase, ANDed with it.
module duty_fix_neg (
  input  logic clk,
  input  logic rst,
  input  logic pos,
  output logic duty
);

  logic neg_q;

  always_ff @(negedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos;
  end

  assign duty = pos & neg_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider with shadowed divisor, glitch-free updates and enable/park.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIV_RST = 5,
  parameter bit          ODD_50  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_active,
  output logic             period_tick,
  output logic             busy
);

  localparam int unsigned THR_W = CNT_W + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] div_clamped;
  logic [THR_W-1:0] thr;
  logic             pos_q;
  logic             at_last;
  logic             apply;

  // A pending divisor may only be applied when no period is in flight.
  assign at_last     = (state == RUN) && (cnt == div_active - CNT_W'(1));
  assign apply       = (state == IDLE) || at_last;
  assign div_clamped = CNT_W'(clamp_div(CLAMP_W'(div_i)));
  assign thr         = ODD_50 ? ((THR_W'(div_active) + THR_W'(1)) >> 1)
                              : (THR_W'(div_active) >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pos_q       <= 1'b0;
      period_tick <= 1'b0;
      div_active  <= CNT_W'(DIV_RST);
      shadow      <= CNT_W'(DIV_RST);
      busy        <= 1'b0;
    end else begin
      // Outputs lag the counter by one cycle, so the tick is armed one count early.
      pos_q       <= (state == RUN) && (THR_W'(cnt) < thr);
      period_tick <= (state == RUN) && (cnt == div_active - CNT_W'(2));

      if (apply && busy) div_active <= shadow;
      if (div_load) begin
        shadow <= div_clamped;
        busy   <= 1'b1;
      end else if (apply) begin
        busy   <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (at_last) begin
            cnt <= '0;
            if (!en) state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  if (ODD_50) begin : g_odd50
    logic duty;
    duty_fix_neg u_duty_fix_neg (
      .clk  (clk),
      .rst  (rst),
      .pos  (pos_q),
      .duty (duty)
    );
    assign clk_out = div_active[0] ? duty : pos_q;
  end else begin : g_plain
    assign clk_out = pos_q;
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed plus randomized bench for prog_clk_divider against a waveform-level reference model.
module tb_prog_clk_divider;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIV_RST = 5;
  localparam bit          ODD_50  = 1'b1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_i;
  logic             clk_out;
  logic [CNT_W-1:0] div_active;
  logic             period_tick;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_clk_divider #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST),
    .ODD_50  (ODD_50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_i       (div_i),
    .div_load    (div_load),
    .clk_out     (clk_out),
    .div_active  (div_active),
    .period_tick (period_tick),
    .busy        (busy)
  );

  // Reference: run flag, cycle index within the output period, divisor in use,
  // pending divisor, and a queue of expected clk_out values per half-cycle.
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend_val;
  bit m_pend;
  bit wq[$];
  bit exp_first;
  bit exp_second;

  function automatic int clampv(int d);
    return (d < 2) ? 2 : d;
  endfunction

  // One output period, starting one clk after the period start edge.
  function automatic void push_period(int n);
    if ((n % 2) == 0) begin
      repeat (n) wq.push_back(1'b1);
      repeat (n) wq.push_back(1'b0);
    end else if (ODD_50) begin
      wq.push_back(1'b0);
      repeat (n) wq.push_back(1'b1);
      repeat (n - 1) wq.push_back(1'b0);
    end else begin
      repeat (n - 1) wq.push_back(1'b1);
      repeat (n + 1) wq.push_back(1'b0);
    end
  endfunction

  function automatic void model_edge();
    bit start;
    bit bnd;
    start = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_n    = DIV_RST;
      m_pend = 1'b0;
      wq.delete();
      repeat (4) wq.push_back(1'b0);
    end else begin
      bnd = !m_run || (m_pos == m_n - 1);
      if (bnd && m_pend) begin
        m_n    = m_pend_val;
        m_pend = 1'b0;
      end
      if (div_load) begin
        m_pend_val = clampv(int'(div_i));
        m_pend     = 1'b1;
      end
      if (m_run) begin
        if (bnd) begin
          m_pos = 0;
          if (en) start = 1'b1;
          else    m_run = 1'b0;
        end else begin
          m_pos++;
        end
      end else if (en) begin
        m_run = 1'b1;
        m_pos = 0;
        start = 1'b1;
      end
      if (start)       push_period(m_n);
      else if (!m_run) repeat (2) wq.push_back(1'b0);
    end
    exp_first  = wq.pop_front();
    exp_second = wq.pop_front();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("clk_out_first_half", 32'(clk_out), 32'(exp_first));
    check("div_active", 32'(div_active), 32'(m_n));
    check("busy", 32'(busy), 32'(m_pend));
    check("period_tick", 32'(period_tick), 32'(m_run && (m_pos == m_n - 1)));
    @(negedge clk);
    #1;
    check("clk_out_second_half", 32'(clk_out), 32'(exp_second));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int v);
    div_i    = CNT_W'(v);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic wait_for(input int n_target, input int pos_target, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_run && m_n == n_target && m_pos == pos_target) found = 1'b1;
      else tick();
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s: timeout waiting for N=%0d pos=%0d, observed N=%0d", tag, n_target, pos_target, m_n);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    div_load = 1'b0;
    div_i    = '0;
    m_run    = 1'b0;
    m_pos    = 0;
    m_n      = DIV_RST;
    m_pend   = 1'b0;
    m_pend_val = DIV_RST;
    repeat (2) wq.push_back(1'b0);

    // Reset held with en high, then free-run at the reset divisor.
    run(3);
    check("reset_div_active", 32'(div_active), 32'(DIV_RST));
    check("reset_clk_out", 32'(clk_out), 32'd0);
    rst = 1'b0;
    run(12);

    // Mid-period load of 4.
    wait_for(5, 2, "wait_n5");
    load(4);
    run(12);

    // Two loads in one period: only the last is applied.
    wait_for(4, 1, "wait_n4");
    load(3);
    load(6);
    run(14);

    // Sub-minimum divisors clamp to 2.
    load(0);
    run(12);
    load(1);
    run(8);

    // Disable at cnt=1 with N=8, then re-enable.
    load(8);
    wait_for(8, 1, "wait_n8");
    en = 1'b0;
    run(12);
    en = 1'b1;
    run(12);

    // Reset in the high phase of N=7 with a load pending.
    load(7);
    wait_for(7, 2, "wait_n7");
    load(9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_div_active", 32'(div_active), 32'(DIV_RST));
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_clk_out", 32'(clk_out), 32'd0);
    run(8);

    // Randomized enable, loads and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(99) == 0);
      en       = ($urandom_range(7) != 0);
      div_load = ($urandom_range(5) == 0);
      div_i    = CNT_W'($urandom_range(12));
      tick();
    end
    rst      = 1'b0;
    div_load = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
